// File: rtl/arm_seq_pkg.sv
// Shared types and constants for the LDM/STM register-list sequencer.
package arm_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    RD,
    MEM,
    WR,
    WB,
    DONE
  } seq_state_t;

  localparam logic [3:0]  REG_PC     = 4'd15;
  localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/reg_list_scan.sv
// Combinational register-list scanner: index of the lowest set bit (with valid) and popcount.
module reg_list_scan (
  input  logic [15:0] i_list,
  output logic [3:0]  o_idx,
  output logic        o_valid,
  output logic [4:0]  o_count
);

  // Walk from the top down so the lowest set bit is the last one written.
  always_comb begin
    o_idx   = '0;
    o_valid = 1'b0;
    o_count = '0;
    for (int unsigned i = 16; i > 0; i--) begin
      if (i_list[i-1]) begin
        o_idx   = 4'(i - 1);
        o_valid = 1'b1;
      end
      o_count = o_count + {4'b0000, i_list[i-1]};
    end
  end

endmodule

// File: rtl/ldm_stm_sequencer.sv
// LDM/STM sequencer: walks a register list one transfer at a time, base writeback last.
// Optional macro SEQ_ALIGN_CHECK_EN adds align_abort for a misaligned base address.
import arm_seq_pkg::*;

module ldm_stm_sequencer #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              start,
  input  logic              is_load,
  input  logic              pre,
  input  logic              up,
  input  logic              wback,
  input  logic [3:0]        base_reg,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [15:0]       reg_list,
  output logic              busy,
  output logic              done,
  output logic [4:0]        rb_address,
  output logic              rb_w,
  output logic [DATA_W-1:0] rb_write,
  input  logic [DATA_W-1:0] rb_read,
  output logic              rb_pc_w,
  output logic [DATA_W-1:0] rb_pc_write,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
`ifdef SEQ_ALIGN_CHECK_EN
  output logic              align_abort,
`endif
  input  logic              mem_ack
);

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(WORD_BYTES);

  seq_state_t        r_state;
  seq_state_t        w_next;

  logic [15:0]       r_list;
  logic              r_is_load;
  logic              r_wback;
  logic              r_rd_phase;
  logic [3:0]        r_base_reg;
  logic [3:0]        r_cur;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_final;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
`ifdef SEQ_ALIGN_CHECK_EN
  logic              r_abort;
  logic              w_misaligned;
`endif

  logic [15:0]       w_scan_list;
  logic [3:0]        w_idx;
  logic              w_valid;
  logic [4:0]        w_count;
  logic [ADDR_W-1:0] w_base;
  logic [ADDR_W-1:0] w_span;
  logic [ADDR_W-1:0] w_start_addr;
  logic [ADDR_W-1:0] w_final;
  logic              w_wb_en;

  // One scanner serves both jobs: popcount of the incoming list in IDLE, lowest pending bit afterwards.
  assign w_scan_list = (r_state == IDLE) ? reg_list : r_list;

  reg_list_scan u_scan (
    .i_list  (w_scan_list),
    .o_idx   (w_idx),
    .o_valid (w_valid),
    .o_count (w_count)
  );

  assign w_base  = base_addr & ~ADDR_W'(3);
  assign w_span  = ADDR_W'(w_count) * STEP;
  assign w_final = up ? (w_base + w_span) : (w_base - w_span);
  // A loaded base wins over writeback, and an empty list never writes back.
  assign w_wb_en = wback && (w_count != 5'd0) && !(is_load && reg_list[base_reg]);
`ifdef SEQ_ALIGN_CHECK_EN
  assign w_misaligned = (base_addr[1:0] != 2'b00);
`endif

  always_comb begin
    w_start_addr = w_base;
    case ({pre, up})
      2'b01:   w_start_addr = w_base;
      2'b11:   w_start_addr = w_base + STEP;
      2'b00:   w_start_addr = w_base - w_span + STEP;
      default: w_start_addr = w_base - w_span;
    endcase
  end

  always_ff @(posedge clk1) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
`ifdef SEQ_ALIGN_CHECK_EN
          w_next = w_misaligned ? DONE : SCAN;
`else
          w_next = SCAN;
`endif
        end
      end
      SCAN: begin
        if (w_valid)      w_next = r_is_load ? MEM : RD;
        else if (r_wback) w_next = WB;
        else              w_next = DONE;
      end
      RD:      if (r_rd_phase) w_next = MEM;
      MEM:     if (mem_ack) w_next = r_is_load ? WR : SCAN;
      WR:      w_next = SCAN;
      WB:      w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // RD spans two cycles: address out, then capture the registered regbank read.
  always_ff @(posedge clk1) begin
    if (rst) begin
      r_list     <= '0;
      r_is_load  <= 1'b0;
      r_wback    <= 1'b0;
      r_rd_phase <= 1'b0;
      r_base_reg <= '0;
      r_cur      <= '0;
      r_addr     <= '0;
      r_final    <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
`ifdef SEQ_ALIGN_CHECK_EN
      r_abort    <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_list     <= reg_list;
            r_is_load  <= is_load;
            r_wback    <= w_wb_en;
            r_base_reg <= base_reg;
            r_addr     <= w_start_addr;
            r_final    <= w_final;
            r_rd_phase <= 1'b0;
`ifdef SEQ_ALIGN_CHECK_EN
            r_abort    <= w_misaligned;
`endif
          end
        end
        SCAN: begin
          r_cur      <= w_idx;
          r_rd_phase <= 1'b0;
        end
        RD: begin
          r_rd_phase <= 1'b1;
          if (r_rd_phase) r_wdata <= rb_read;
        end
        MEM: begin
          if (mem_ack) begin
            if (r_is_load) begin
              r_rdata <= mem_rdata;
            end else begin
              r_list[r_cur] <= 1'b0;
              r_addr        <= r_addr + STEP;
            end
          end
        end
        WR: begin
          r_list[r_cur] <= 1'b0;
          r_addr        <= r_addr + STEP;
        end
        DONE: begin
`ifdef SEQ_ALIGN_CHECK_EN
          r_abort <= 1'b0;
`endif
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy        = (r_state != IDLE);
    done        = 1'b0;
    rb_address  = '0;
    rb_w        = 1'b0;
    rb_write    = '0;
    rb_pc_w     = 1'b0;
    rb_pc_write = '0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
`ifdef SEQ_ALIGN_CHECK_EN
    align_abort = 1'b0;
`endif
    case (r_state)
      RD: rb_address = {1'b0, r_cur};
      MEM: begin
        mem_req   = 1'b1;
        mem_we    = !r_is_load;
        mem_addr  = r_addr;
        mem_wdata = r_is_load ? '0 : r_wdata;
      end
      WR: begin
        if (r_cur == REG_PC) begin
          rb_pc_w     = 1'b1;
          rb_pc_write = r_rdata;
        end else begin
          rb_w       = 1'b1;
          rb_address = {1'b0, r_cur};
          rb_write   = r_rdata;
        end
      end
      WB: begin
        rb_w       = 1'b1;
        rb_address = {1'b0, r_base_reg};
        rb_write   = DATA_W'(r_final);
      end
      DONE: begin
        done = 1'b1;
`ifdef SEQ_ALIGN_CHECK_EN
        align_abort = r_abort;
`endif
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Scoreboard bench for ldm_stm_sequencer: reference model queues expected transfers, monitor checks them.
module tb_ldm_stm_sequencer;

  localparam logic [3:0] K_MEMW = 4'd1;
  localparam logic [3:0] K_MEMR = 4'd2;
  localparam logic [3:0] K_RBW  = 4'd3;
  localparam logic [3:0] K_PCW  = 4'd4;
  localparam logic [3:0] K_DONE = 4'd5;

  typedef struct packed {
    logic [3:0]  kind;
    logic [4:0]  rn;
    logic [31:0] addr;
    logic [31:0] data;
  } ev_t;

  logic        clk1, rst, start, is_load, pre, up, wback;
  logic [3:0]  base_reg;
  logic [31:0] base_addr;
  logic [15:0] reg_list;
  logic        busy, done, rb_w, rb_pc_w, mem_req, mem_we, mem_ack;
  logic [4:0]  rb_address;
  logic [31:0] rb_write, rb_read, rb_pc_write, mem_addr, mem_wdata, mem_rdata;

  ldm_stm_sequencer #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk1(clk1), .rst(rst), .start(start), .is_load(is_load), .pre(pre), .up(up),
    .wback(wback), .base_reg(base_reg), .base_addr(base_addr), .reg_list(reg_list),
    .busy(busy), .done(done), .rb_address(rb_address), .rb_w(rb_w), .rb_write(rb_write),
    .rb_read(rb_read), .rb_pc_w(rb_pc_w), .rb_pc_write(rb_pc_write), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          n_xfer   = 0;
  int          ack_mode = 0;
  bit          spurious = 0;
  bit          garbage  = 0;
  ev_t         sb[$];
  logic [31:0] regs[16];
  logic [31:0] mem_img[logic [31:0]];

  initial begin
    clk1 = 1'b0;
    forever #5 clk1 = ~clk1;
  end

  always @(posedge clk1) begin
    cyc     <= cyc + 1;
    rb_read <= regs[rb_address[3:0]];
  end

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic ev_t mk(input logic [3:0] k, input logic [4:0] rn,
                             input logic [31:0] a, input logic [31:0] d);
    ev_t e;
    e.kind = k; e.rn = rn; e.addr = a; e.data = d;
    return e;
  endfunction

  task automatic expect_ev(input string nm, input ev_t act);
    ev_t e;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s unexpected actual=%h required=none", nm, act);
    end else begin
      e = sb.pop_front();
      chk(nm, 80'(act), 80'(e));
    end
  endtask

  // Memory responder: programmable ack latency, optional stray acks while idle.
  initial begin
    int wcnt;
    int dly;
    mem_ack = 1'b0;
    mem_rdata = '0;
    wcnt = 0;
    dly = 0;
    forever begin
      @(posedge clk1);
      #1;
      if (mem_req) begin
        if (wcnt >= dly) begin
          mem_ack   = 1'b1;
          mem_rdata = mem_img.exists(mem_addr) ? mem_img[mem_addr] : 32'hDEAD_BEEF;
        end else begin
          mem_ack = 1'b0;
          wcnt++;
        end
      end else begin
        wcnt      = 0;
        dly       = (ack_mode < 0) ? int'($urandom_range(0, 3)) : ack_mode;
        mem_ack   = spurious && ($urandom_range(0, 5) == 0);
        mem_rdata = $urandom;
      end
    end
  end

  // Monitor: every strobe / completed transfer pops one expected event.
  initial begin
    logic        p_req, p_ack, p_we;
    logic [31:0] p_addr, p_wdata;
    p_req = 1'b0; p_ack = 1'b0; p_we = 1'b0; p_addr = '0; p_wdata = '0;
    forever begin
      @(negedge clk1);
      if (rst) begin
        p_req = 1'b0;
      end else begin
        if (p_req && !p_ack) begin
          chk("mem_hold", {45'd0, mem_req, mem_we, mem_addr, mem_wdata},
                          {45'd0, 1'b1, p_we, p_addr, p_wdata});
        end
        if (rb_w && rb_pc_w) chk("rbw_pcw_excl", 80'({rb_w, rb_pc_w}), 80'(2'b10));
        if (mem_req && mem_ack) begin
          n_xfer++;
          expect_ev("mem_xfer", mk(mem_we ? K_MEMW : K_MEMR, 5'd0, mem_addr,
                                   mem_we ? mem_wdata : 32'd0));
        end
        if (rb_w) begin
          chk("rb_addr_bit4", 80'(rb_address[4]), 80'(1'b0));
          expect_ev("rb_write", mk(K_RBW, rb_address, 32'd0, rb_write));
        end
        if (rb_pc_w) expect_ev("pc_write", mk(K_PCW, 5'd0, 32'd0, rb_pc_write));
        if (done)    expect_ev("done", mk(K_DONE, 5'd0, 32'd0, 32'd0));
        p_req = mem_req; p_ack = mem_ack; p_we = mem_we; p_addr = mem_addr; p_wdata = mem_wdata;
      end
    end
  end

  // Reference model: derives the whole transfer sequence from list, base and P/U/W/L bits.
  task automatic model(input bit ld, input bit p, input bit u, input bit w,
                       input logic [3:0] br, input logic [31:0] base, input logic [15:0] lst);
    int          n;
    logic [31:0] a;
    n = $countones(lst);
    if (u) a = p ? base + 32'd4 : base;
    else   a = p ? base - 32'(4 * n) : base - 32'(4 * n) + 32'd4;
    for (int i = 0; i < 16; i++) begin
      if (lst[i]) begin
        if (ld) begin
          if (!mem_img.exists(a)) mem_img[a] = $urandom;
          sb.push_back(mk(K_MEMR, 5'd0, a, 32'd0));
          if (i == 15) sb.push_back(mk(K_PCW, 5'd0, 32'd0, mem_img[a]));
          else         sb.push_back(mk(K_RBW, 5'(i), 32'd0, mem_img[a]));
        end else begin
          sb.push_back(mk(K_MEMW, 5'd0, a, regs[i]));
        end
        a = a + 32'd4;
      end
    end
    if (w && n != 0 && !(ld && lst[br]))
      sb.push_back(mk(K_RBW, {1'b0, br}, 32'd0, u ? base + 32'(4 * n) : base - 32'(4 * n)));
    sb.push_back(mk(K_DONE, 5'd0, 32'd0, 32'd0));
  endtask

  task automatic drive_start(input bit ld, input bit p, input bit u, input bit w,
                             input logic [3:0] br, input logic [31:0] base, input logic [15:0] lst);
    regs[br] = base;
    model(ld, p, u, w, br, base, lst);
    is_load = ld; pre = p; up = u; wback = w; base_reg = br; base_addr = base; reg_list = lst;
    start = 1'b1;
    @(posedge clk1);
    #1;
    start = 1'b0;
    chk("busy_after_start", 80'(busy), 80'(1'b1));
  endtask

  task automatic run_op(input bit ld, input bit p, input bit u, input bit w,
                        input logic [3:0] br, input logic [31:0] base, input logic [15:0] lst,
                        output int lat);
    int  t0;
    bit  seen;
    drive_start(ld, p, u, w, br, base, lst);
    t0 = cyc;
    seen = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (garbage) begin
        start    = ($urandom_range(0, 3) == 0);
        is_load  = 1'($urandom);
        reg_list = 16'($urandom);
        base_addr = $urandom;
        base_reg = 4'($urandom);
      end
      @(posedge clk1);
      #1;
    end
    start = 1'b0;
    lat = cyc - t0 + 1;
    if (!seen) chk("done_timeout", 80'(seen), 80'(1'b1));
    @(posedge clk1);
    #1;
    chk("busy_after_done", 80'(busy), 80'(1'b0));
    chk("sb_drained", 80'(sb.size()), 80'(0));
  endtask

  initial begin
    int lat;
    int x0;
    bit hit;
    rst = 1'b1; start = 1'b0; is_load = 1'b0; pre = 1'b0; up = 1'b0; wback = 1'b0;
    base_reg = '0; base_addr = '0; reg_list = '0;
    for (int i = 0; i < 16; i++) regs[i] = $urandom;
    repeat (3) @(posedge clk1);
    #1;
    chk("reset_ctl", 80'({busy, done, rb_w, rb_pc_w, mem_req, mem_we, rb_address}), 80'(0));
    chk("reset_data", 80'(rb_write | rb_pc_write | mem_addr | mem_wdata), 80'(0));
    rst = 1'b0;
    @(posedge clk1);
    #1;

    // STM IA, R0/R1/R3 from 0x100, writeback 0x10C, same-cycle ack
    ack_mode = 0;
    run_op(1'b0, 1'b0, 1'b1, 1'b1, 4'd5, 32'h100, 16'h000B, lat);

    // LDM DB with R15: words 0xA,0xB,0xC at 0x1F4..0x1FC
    mem_img.delete();
    mem_img[32'h1F4] = 32'hA; mem_img[32'h1F8] = 32'hB; mem_img[32'h1FC] = 32'hC;
    run_op(1'b1, 1'b1, 1'b0, 1'b0, 4'd6, 32'h200, 16'h8003, lat);

    // slow memory, both directions
    ack_mode = 3;
    run_op(1'b0, 1'b0, 1'b0, 1'b1, 4'd9, 32'h0000_0400, 16'h00F0, lat);
    mem_img.delete();
    run_op(1'b1, 1'b1, 1'b1, 1'b1, 4'd1, 32'h0000_0800, 16'h0C21, lat);

    // LDM with base in list: loaded value, no writeback
    ack_mode = 0;
    mem_img.delete();
    run_op(1'b1, 1'b0, 1'b1, 1'b1, 4'd2, 32'h300, 16'h0004, lat);

    // STM with base in list stores original base
    run_op(1'b0, 1'b1, 1'b1, 1'b1, 4'd4, 32'h500, 16'h0014, lat);

    // empty list with W=1
    run_op(1'b0, 1'b0, 1'b1, 1'b1, 4'd3, 32'h700, 16'h0000, lat);
    chk("empty_done_latency", 80'(lat), 80'(2));

    // reset during MEM of the second transfer
    ack_mode = 3;
    drive_start(1'b0, 1'b0, 1'b1, 1'b1, 4'd8, 32'h900, 16'h0007);
    x0 = n_xfer;
    hit = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (mem_req && (n_xfer - x0) == 1) begin
        hit = 1'b1;
        break;
      end
      @(posedge clk1);
      #1;
    end
    chk("reach_second_mem", 80'(hit), 80'(1'b1));
    rst = 1'b1;
    sb.delete();
    @(posedge clk1);
    #1;
    chk("midrst_ctl", 80'({busy, done, rb_w, rb_pc_w, mem_req, mem_we, rb_address}), 80'(0));
    chk("midrst_data", 80'(rb_write | rb_pc_write | mem_addr | mem_wdata), 80'(0));
    rst = 1'b0;
    repeat (4) @(posedge clk1);
    #1;
    chk("idle_after_rst", 80'({busy, mem_req}), 80'(0));
    run_op(1'b0, 1'b1, 1'b0, 1'b1, 4'd8, 32'h900, 16'h0007, lat);

    // randomized operations with stray acks and ignored mid-op starts
    ack_mode = -1;
    spurious = 1'b1;
    garbage  = 1'b1;
    for (int k = 0; k < 40; k++) begin
      logic [15:0] lst;
      int          sel;
      sel = int'($urandom_range(0, 9));
      if (sel == 0)      lst = 16'h0000;
      else if (sel == 1) lst = 16'h0001 << $urandom_range(0, 15);
      else               lst = 16'($urandom);
      for (int i = 0; i < 16; i++) regs[i] = $urandom;
      mem_img.delete();
      run_op(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom),
             $urandom & 32'hFFFF_FFFC, lst, lat);
    end
    garbage  = 1'b0;
    spurious = 1'b0;

    repeat (3) @(posedge clk1);
    #1;
    chk("sb_final_empty", 80'(sb.size()), 80'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
